// File: rtl/jam_pkg.sv
// Widths and tag type shared by the JAM engines
// and the cost-ROM arbiter.
package jam_pkg;

  localparam int COST_W  = 7;
  localparam int IDX_W   = 3;
  localparam int MAX_REQ = 4;
  localparam int ID_W    = 2;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/cost_rr_pick.sv
// Round-robin pick: first requester at or after PTR,
// modulo NREQ. Purely combinational.
module cost_rr_pick
  import jam_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] REQ,
  input  logic [ID_W-1:0] PTR,
  output logic [NREQ-1:0] GNT,
  output logic [ID_W-1:0] IDX
);

  logic found;
  int   s;

  always_comb begin
    GNT   = '0;
    IDX   = '0;
    found = 1'b0;
    s     = 0;
    for (int k = 0; k < NREQ; k++) begin
      s = (int'(PTR) + k) % NREQ;
      if (!found && REQ[s]) begin
        found  = 1'b1;
        GNT[s] = 1'b1;
        IDX    = ID_W'(s);
      end
    end
  end

endmodule

// File: rtl/cost_rom_arbiter.sv
// Shares one cost-ROM read port between JAM engines;
// returning Cost is steered by a 2-deep tag pipe.
module cost_rom_arbiter
  import jam_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ,
  input  logic [IDX_W*NREQ-1:0] REQ_W,
  input  logic [IDX_W*NREQ-1:0] REQ_J,
  output logic [NREQ-1:0]       GNT,
  output logic [NREQ-1:0]       RVALID,
  output logic [COST_W-1:0]     RDATA,
  output logic [IDX_W-1:0]      W,
  output logic [IDX_W-1:0]      J,
  input  logic [COST_W-1:0]     Cost,
  output logic                  BUSY
);

  localparam logic [NREQ-1:0] ONE = 1;

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  gidx;
  logic             acc;
  logic [IDX_W-1:0] gw;
  logic [IDX_W-1:0] gj;
  tag_t             s1;
  tag_t             s2;

  cost_rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .REQ(REQ),
    .PTR(ptr),
    .GNT(GNT),
    .IDX(gidx)
  );

  assign acc = |GNT;

  always_comb begin
    gw = '0;
    gj = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (GNT[i]) begin
        gw = REQ_W[IDX_W*i +: IDX_W];
        gj = REQ_J[IDX_W*i +: IDX_W];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr    <= '0;
      W      <= '0;
      J      <= '0;
      s1     <= '0;
      s2     <= '0;
      RVALID <= '0;
      RDATA  <= '0;
    end else begin
      s1 <= '{valid: acc, id: gidx};
      s2 <= s1;
      if (acc) begin
        W   <= gw;
        J   <= gj;
        ptr <= (gidx == ID_W'(NREQ-1)) ? '0 : gidx + 1'b1;
      end
      // ROM output now reflects the address captured one edge ago
      if (s2.valid) begin
        RDATA  <= Cost;
        RVALID <= ONE << s2.id;
      end else begin
        RVALID <= '0;
      end
    end
  end

  assign BUSY = s1.valid | s2.valid;

endmodule

// File: tb/tb_cost_rom_arbiter.sv
// Bench for cost_rom_arbiter: NREQ=2 and NREQ=4 instances,
// each with a ROM model cost[W][J] = 8W+J.
module tb_cost_rom_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]  r2;
  logic [5:0]  w2, j2;
  logic [1:0]  g2, rv2;
  logic [6:0]  rd2, c2;
  logic [2:0]  W2, J2, rw2, rj2;
  logic        b2;

  logic [3:0]  r4;
  logic [11:0] w4, j4;
  logic [3:0]  g4, rv4;
  logic [6:0]  rd4, c4;
  logic [2:0]  W4, J4, rw4, rj4;
  logic        b4;

  always #5 clk = ~clk;

  cost_rom_arbiter #(.NREQ(2)) u2 (
    .CLK(clk), .RST(rst), .REQ(r2), .REQ_W(w2), .REQ_J(j2),
    .GNT(g2), .RVALID(rv2), .RDATA(rd2), .W(W2), .J(J2),
    .Cost(c2), .BUSY(b2)
  );

  cost_rom_arbiter #(.NREQ(4)) u4 (
    .CLK(clk), .RST(rst), .REQ(r4), .REQ_W(w4), .REQ_J(j4),
    .GNT(g4), .RVALID(rv4), .RDATA(rd4), .W(W4), .J(J4),
    .Cost(c4), .BUSY(b4)
  );

  // ROM: registered address, combinational data
  always @(posedge clk) begin
    rw2 <= W2; rj2 <= J2;
    rw4 <= W4; rj4 <= J4;
  end
  assign c2 = {1'b0, rw2, rj2};
  assign c4 = {1'b0, rw4, rj4};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  // Reference model: pending reads with their due cycle
  typedef struct {
    int due;
    int id;
    int data;
  } rd_t;

  rd_t mq [2][$];
  int  nr [2] = '{2, 4};
  int  mptr [2];
  int  mw [2];
  int  mj [2];
  int  mlast [2];
  int  rvcnt [2];
  int  cycle = 0;
  logic [1:0] obs_g2;
  logic [3:0] obs_g4;

  function automatic int pick(int n, int p, logic [3:0] r);
    for (int k = 0; k < n; k++) begin
      int i;
      i = (p + k) % n;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      mptr[d] = 0; mw[d] = 0; mj[d] = 0; mlast[d] = 0;
    end
  endtask

  task automatic do_reset();
    r2 = '0; r4 = '0;
    rst = 1'b0;
    model_clear();
    #1;
    chk("rst_rv2", int'(rv2), 0);
    chk("rst_rd2", int'(rd2), 0);
    chk("rst_wj2", int'({W2, J2}), 0);
    chk("rst_busy2", int'(b2), 0);
    chk("rst_gnt2", int'(g2), 0);
    chk("rst_rv4", int'(rv4), 0);
    chk("rst_rd4", int'(rd4), 0);
    chk("rst_wj4", int'({W4, J4}), 0);
    chk("rst_busy4", int'(b4), 0);
    @(posedge clk);
    cycle++;
    #1;
    rst = 1'b1;
  endtask

  // One clock: drive, check grant, clock, check registered outputs
  task automatic cyc(input logic [3:0] q2r, input logic [11:0] q2w,
                     input logic [11:0] q2j, input logic [3:0] q4r,
                     input logic [11:0] q4w, input logic [11:0] q4j);
    logic [3:0]  rq [2];
    logic [11:0] aw [2];
    logic [11:0] aj [2];
    int          g [2];
    string       sfx;
    int          erv, arv, ard, ab, awj;
    rq[0] = q2r; rq[1] = q4r;
    aw[0] = q2w; aw[1] = q4w;
    aj[0] = q2j; aj[1] = q4j;
    r2 = q2r[1:0]; w2 = q2w[5:0]; j2 = q2j[5:0];
    r4 = q4r; w4 = q4w; j4 = q4j;
    #1;
    obs_g2 = g2; obs_g4 = g4;
    for (int d = 0; d < 2; d++) begin
      sfx = (d == 0) ? "2" : "4";
      g[d] = pick(nr[d], mptr[d], rq[d]);
      chk({"gnt", sfx}, (d == 0) ? int'(g2) : int'(g4),
          (g[d] < 0) ? 0 : (1 << g[d]));
    end
    @(posedge clk);
    cycle++;
    for (int d = 0; d < 2; d++) begin
      if (g[d] >= 0) begin
        mw[d] = int'(aw[d][3*g[d] +: 3]);
        mj[d] = int'(aj[d][3*g[d] +: 3]);
        mq[d].push_back('{cycle + 2, g[d], (8 * mw[d] + mj[d]) % 128});
        mptr[d] = (g[d] + 1) % nr[d];
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      sfx = (d == 0) ? "2" : "4";
      erv = 0;
      if (mq[d].size() > 0 && mq[d][0].due == cycle) begin
        erv = 1 << mq[d][0].id;
        mlast[d] = mq[d][0].data;
        void'(mq[d].pop_front());
        rvcnt[d]++;
      end
      arv = (d == 0) ? int'(rv2) : int'(rv4);
      ard = (d == 0) ? int'(rd2) : int'(rd4);
      ab  = (d == 0) ? int'(b2) : int'(b4);
      awj = (d == 0) ? int'({W2, J2}) : int'({W4, J4});
      chk({"rvalid", sfx}, arv, erv);
      chk({"rdata", sfx}, ard, mlast[d]);
      chk({"busy", sfx}, ab, (mq[d].size() > 0) ? 1 : 0);
      chk({"wj", sfx}, awj, mw[d] * 8 + mj[d]);
    end
  endtask

  typedef struct {
    bit         rst;
    logic [1:0] req;
    logic [5:0] w;
    logic [5:0] j;
    logic [1:0] gnt;
    logic [1:0] rv;
    int         rd;
    bit         busy;
  } vec_t;

  vec_t tv [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  act2, act4;
    logic [11:0] a2w, a2j, a4w, a4j, fw, fj;
    int          gcnt [4];
    int          p [2];
    int          base;

    tv[0]  = '{1, 2'b01, 6'b000_010, 6'b000_101, 2'b01, 2'b00, 0,  1};
    tv[1]  = '{0, 2'b00, 6'b0,       6'b0,       2'b00, 2'b00, 0,  1};
    tv[2]  = '{0, 2'b00, 6'b0,       6'b0,       2'b00, 2'b01, 21, 0};
    tv[3]  = '{0, 2'b00, 6'b0,       6'b0,       2'b00, 2'b00, 21, 0};
    tv[4]  = '{0, 2'b10, 6'b111_000, 6'b111_000, 2'b10, 2'b00, 21, 1};
    tv[5]  = '{0, 2'b01, 6'b000_001, 6'b000_001, 2'b01, 2'b00, 21, 1};
    tv[6]  = '{0, 2'b00, 6'b0,       6'b0,       2'b00, 2'b10, 63, 1};
    tv[7]  = '{0, 2'b00, 6'b0,       6'b0,       2'b00, 2'b01, 9,  0};
    tv[8]  = '{1, 2'b11, 6'b111_001, 6'b111_001, 2'b01, 2'b00, 0,  1};
    tv[9]  = '{0, 2'b11, 6'b111_001, 6'b111_001, 2'b10, 2'b00, 0,  1};
    tv[10] = '{0, 2'b00, 6'b0,       6'b0,       2'b00, 2'b01, 9,  1};
    tv[11] = '{0, 2'b00, 6'b0,       6'b0,       2'b00, 2'b10, 63, 0};

    r2 = '0; w2 = '0; j2 = '0;
    r4 = '0; w4 = '0; j4 = '0;
    #3;
    do_reset();

    // Single read, pointer wrap, contention from reset
    for (int t = 0; t < 12; t++) begin
      if (tv[t].rst) do_reset();
      cyc({2'b00, tv[t].req}, {6'b0, tv[t].w}, {6'b0, tv[t].j},
          4'b0, 12'b0, 12'b0);
      chk("tv_gnt", int'(obs_g2), int'(tv[t].gnt));
      chk("tv_rvalid", int'(rv2), int'(tv[t].rv));
      chk("tv_rdata", int'(rd2), tv[t].rd);
      chk("tv_busy", int'(b2), int'(tv[t].busy));
    end

    // Reset while a read is in flight
    cyc(4'b0001, 12'o0005, 12'o0003, 4'b0, 12'b0, 12'b0);
    cyc(4'b0, 12'b0, 12'b0, 4'b0, 12'b0, 12'b0);
    do_reset();
    for (int t = 0; t < 4; t++)
      cyc(4'b0, 12'b0, 12'b0, 4'b0, 12'b0, 12'b0);
    chk("midrst_rdata", int'(rd2), 0);

    // Fairness on NREQ=4
    do_reset();
    for (int i = 0; i < 4; i++) begin
      gcnt[i] = 0;
      fw[3*i +: 3] = 3'(i);
      fj[3*i +: 3] = 3'(7 - i);
    end
    for (int t = 0; t < 40; t++) begin
      cyc(4'b0, 12'b0, 12'b0, 4'hF, fw, fj);
      for (int i = 0; i < 4; i++) gcnt[i] += int'(obs_g4[i]);
    end
    for (int i = 0; i < 4; i++) chk("fair_cnt", gcnt[i], 10);
    for (int t = 0; t < 3; t++)
      cyc(4'b0, 12'b0, 12'b0, 4'b0, 12'b0, 12'b0);

    // Full 64-entry sweep split across two engines
    p[0] = 0; p[1] = 32;
    base = rvcnt[0];
    for (int c = 0; c < 200 && (p[0] < 32 || p[1] < 64); c++) begin
      logic [1:0] rq;
      logic [5:0] sw, sj;
      rq[0] = (p[0] < 32);
      rq[1] = (p[1] < 64);
      sw = {3'(p[1] / 8), 3'(p[0] / 8)};
      sj = {3'(p[1] % 8), 3'(p[0] % 8)};
      cyc({2'b0, rq}, {6'b0, sw}, {6'b0, sj}, 4'b0, 12'b0, 12'b0);
      if (obs_g2[0]) p[0]++;
      if (obs_g2[1]) p[1]++;
    end
    chk("sweep_done", p[0] + p[1], 96);
    for (int t = 0; t < 3; t++)
      cyc(4'b0, 12'b0, 12'b0, 4'b0, 12'b0, 12'b0);
    chk("sweep_rvalids", rvcnt[0] - base, 64);

    // Random requests, withdrawals and occasional resets
    act2 = '0; act4 = '0;
    a2w = '0; a2j = '0; a4w = '0; a4j = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
        act2 = '0; act4 = '0;
      end
      for (int i = 0; i < 4; i++) begin
        if (!act4[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            act4[i] = 1'b1;
            a4w[3*i +: 3] = 3'($urandom_range(0, 7));
            a4j[3*i +: 3] = 3'($urandom_range(0, 7));
          end
        end else if ($urandom_range(0, 7) == 0) begin
          act4[i] = 1'b0;
        end
        if (i < 2) begin
          if (!act2[i]) begin
            if ($urandom_range(0, 1) == 1) begin
              act2[i] = 1'b1;
              a2w[3*i +: 3] = 3'($urandom_range(0, 7));
              a2j[3*i +: 3] = 3'($urandom_range(0, 7));
            end
          end else if ($urandom_range(0, 7) == 0) begin
            act2[i] = 1'b0;
          end
        end
      end
      cyc(act2, a2w, a2j, act4, a4w, a4j);
      act2 = act2 & ~{2'b00, obs_g2};
      act4 = act4 & ~obs_g4;
    end
    for (int t = 0; t < 3; t++)
      cyc(4'b0, 12'b0, 12'b0, 4'b0, 12'b0, 12'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cost_rom_arbiter.md
# cost_rom_arbiter

Shares the single cost-ROM read port (W/J address out, 7-bit Cost back) between several job-assignment search engines, so that parallel JAM engines can each search a slice of the permutation space against one cost table. Arbitration is round-robin with at most one grant per cycle. Returning Cost is steered to the owning requester through a 2-deep tag pipeline. The block sits between the engines and the cost ROM; the ROM is unchanged: it registers W/J on CLK and presents Cost combinationally from the registered address.

## Interface
- NREQ, 2, number of requesters, legal 2..4
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset
- REQ  in  NREQ  per-requester read request, level; held until granted
- REQ_W  in  3*NREQ  worker index of requester i in bits [3i+2:3i]
- REQ_J  in  3*NREQ  job index of requester i in bits [3i+2:3i]
- GNT  out  NREQ  one-hot-or-zero grant, combinational from REQ and priority pointer
- RVALID  out  NREQ  one-hot-or-zero, registered; RDATA belongs to requester i
- RDATA  out  7  registered Cost for the granted read
- W  out  3  registered worker address to the ROM
- J  out  3  registered job address to the ROM
- Cost  in  7  ROM data, valid in the cycle after the ROM captures W/J
- BUSY  out  1  registered; high while any read is in flight

## Operation
- Priority pointer `ptr` (0..NREQ-1) marks the highest-priority requester. GNT[i] = 1 for the first i with REQ[i]=1, scanning ptr, ptr+1, … modulo NREQ. At most one bit is set.
- Accept = REQ[i] && GNT[i] at a rising edge. On accept:
  - W <= REQ_W[i], J <= REQ_J[i].
  - Stage-1 tag <= {valid=1, id=i}.
  - ptr <= (i+1) mod NREQ, wrapping NREQ-1 -> 0.
- No accept: ptr holds, W/J hold their last value, stage-1 valid <= 0.
- Every edge, stage-1 tag shifts to stage 2. If stage-2 valid is set, RDATA <= Cost and RVALID <= onehot(stage-2 id); otherwise RVALID <= 0 and RDATA holds.
- The pipeline is fully pipelined: one accept per cycle, up to 2 reads in flight, no backpressure from requesters. A requester must take RDATA in the cycle RVALID is high.
- A requester may change its address only after it is accepted. Dropping REQ before grant withdraws the request with no side effect.
- BUSY = stage-1 valid | stage-2 valid.

## Timing
- Reset (RST=0, asynchronous): ptr=0, W=0, J=0, both tag stages invalid, RVALID=0, RDATA=0, BUSY=0. GNT is then a function of REQ only, with ptr=0.
- Accept at edge n:
  - W/J drive the new address after edge n.
  - The ROM captures it at edge n+1.
  - RDATA/RVALID are set at edge n+2 and high during cycle n+2..n+3.
  - Grant-to-data latency is 2 cycles.
- Back-to-back accepts at edges n, n+1 give RVALID in consecutive cycles, in accept order.
- All NREQ requesting continuously: grants rotate 0,1,…,NREQ-1,0,… Each requester gets exactly 1 grant in every NREQ cycles.
- Reset asserted mid-operation: in-flight reads are discarded. No RVALID is produced for them after reset release. Requesters must re-issue.
- REQ released in the same cycle as RST deasserts: no grant is recorded.

## Structure
- Shared package jam_pkg holds:
  - COST_W=7, IDX_W=3, MAX_REQ=4
  - typedef tag_t {logic valid; logic [1:0] id;}
  - The same package is used by the JAM engines.
- One sub-module, cost_rr_pick: purely combinational; inputs REQ and ptr, outputs one-hot GNT and the granted index. It is reused by any future shared-resource arbiter.
- The top level holds ptr, the W/J registers, the 2-stage tag pipe, and the RDATA/RVALID registers.

## Test plan
The bench loads the ROM with cost[W][J] = 8W+J (mod 128) and runs with NREQ=2 unless noted.
- Single read: REQ[0]=1, W=2, J=5 at edge n, REQ[1]=0 -> GNT=01 at n; RVALID=01 and RDATA=21 at n+2; BUSY high for 2 cycles.
- Contention: both requesters hold REQ, requester 0 at (1,1), requester 1 at (7,7), from reset -> grants 0 then 1. RVALID=01 with RDATA=9, then RVALID=10 with RDATA=63, in consecutive cycles.
- Fairness: NREQ=4, all REQ high for 40 cycles -> each requester gets 10 grants; the grant sequence is 0,1,2,3 repeated; RVALID is one-hot every cycle after the 2-cycle fill.
- Pointer wrap: only requester NREQ-1 requests, then only requester 0 -> ptr goes 0 -> 0 (wrap) and requester 0 is granted immediately.
- Reset mid-flight: accept at edge n, RST=0 between n+1 and n+2 -> RVALID stays 0 and RDATA=0; after release, W=J=0 and BUSY=0.
- Full JAM sweep: two engines together issue all 64 (W,J) pairs -> every RDATA equals 8W+J, with no lost or duplicated RVALID.
